// File: rtl/instr_encoder.sv
// Instruction encoder / program-memory writer: packs commands into 13-bit words,
// stores them from address 0 upward and always closes the program with a halt.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_valve,
  input  logic              cmd_set,
  input  logic [5:0]        cmd_delay,
  input  logic [2:0]        cmd_unit,
  input  logic              cmd_debug,
  input  logic              rewind,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [12:0]       mem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              prog_done,
  output logic              overflow,
  output logic              err_illegal,
  output logic              dbg_state
);

  // Handshake: a command transfers in any cycle where cmd_valid && cmd_ready.
  // cmd_ready never looks at cmd_valid; the sender holds the command stable
  // until it transfers.

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [1:0]      OP_SET    = 2'd0;
  localparam logic [1:0]      OP_DELAY  = 2'd1;
  localparam logic [1:0]      OP_HALT   = 2'd2;
  localparam logic [12:0]     HALT_WORD = 13'h0C00;
  localparam logic [ADDR_W:0] PTR_LAST  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] PTR_FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_wr_ptr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [12:0]       r_mem_wdata;
  logic              r_ovf;
  logic              r_err;

  logic              w_ready;
  logic              w_accept;
  logic              w_last;
  logic              w_write;
  logic              w_force_halt;
  logic              w_illegal;
  logic [12:0]       w_word;
  logic [12:0]       w_set_word;
  logic [12:0]       w_delay_word;

  assign w_set_word   = {3'b001, cmd_valve, 4'b0000, cmd_set, 1'b0};
  assign w_delay_word = {3'b010, cmd_delay, cmd_unit, cmd_debug};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  // The last slot is reserved for a halt: a set/delay landing there is
  // replaced by a forced halt so the program counter can never run off the end.
  always_comb begin
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_force_halt = 1'b0;
    w_illegal    = 1'b0;
    w_word       = 13'h0000;
    w_ready      = (r_state == ST_FILL) && !rewind && !rst;
    w_accept     = cmd_valid && w_ready;
    w_last       = (r_wr_ptr == PTR_LAST);
    if (rewind) begin
      w_state_nxt = ST_FILL;
    end else if (w_accept) begin
      case (cmd_op)
        OP_SET, OP_DELAY: begin
          w_write = 1'b1;
          if (w_last) begin
            w_word       = HALT_WORD;
            w_force_halt = 1'b1;
            w_state_nxt  = ST_DONE;
          end else begin
            w_word = (cmd_op == OP_SET) ? w_set_word : w_delay_word;
          end
        end
        OP_HALT: begin
          w_write     = 1'b1;
          w_word      = HALT_WORD;
          w_state_nxt = ST_DONE;
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 13'h0000;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_write;
      r_err    <= w_illegal;
      if (w_write) begin
        r_mem_addr  <= r_wr_ptr[ADDR_W-1:0];
        r_mem_wdata <= w_word;
      end
      // The output write registered last cycle still completes during rewind.
      if (rewind) begin
        r_wr_ptr <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_write && (r_wr_ptr != PTR_FULL)) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_force_halt) r_ovf <= 1'b1;
      end
    end
  end

  assign cmd_ready   = w_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign prog_len    = r_wr_ptr;
  assign prog_done   = (r_state == ST_DONE);
  assign overflow    = r_ovf;
  assign err_illegal = r_err;
  assign dbg_state   = (r_state == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, hand-written corner sequences and
// random traffic checked against a program-level reference model.
module tb_instr_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int W     = AW + 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [3:0]    cmd_valve;
  logic          cmd_set;
  logic [5:0]    cmd_delay;
  logic [2:0]    cmd_unit;
  logic          cmd_debug;
  logic          rewind;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [12:0]   mem_wdata;
  logic [AW:0]   prog_len;
  logic          prog_done;
  logic          overflow;
  logic          err_illegal;
  logic          dbg_state;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_valve(cmd_valve), .cmd_set(cmd_set),
    .cmd_delay(cmd_delay), .cmd_unit(cmd_unit), .cmd_debug(cmd_debug),
    .rewind(rewind), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .prog_len(prog_len), .prog_done(prog_done),
    .overflow(overflow), .err_illegal(err_illegal), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard and reference model: the program as a list of stored words.
  logic [W-1:0] exp_q[$];
  int           m_len  = 0;
  bit           m_done = 1'b0;
  bit           m_ovf  = 1'b0;
  bit           e_we   = 1'b0;
  bit           e_err  = 1'b0;

  int           wr_count  = 0;
  int           err_count = 0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [12:0]  last_wr_data = 13'h0000;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  valve;
    logic        st;
    logic [5:0]  dl;
    logic [2:0]  un;
    logic        db;
    logic [12:0] word;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [12:0] ref_word(input logic [1:0] op, input logic [3:0] valve,
                                           input logic st, input logic [5:0] dl,
                                           input logic [2:0] un, input logic db);
    int w;
    case (op)
      2'd0:    w = 1 * 1024 + int'(valve) * 64 + int'(st) * 2;
      2'd1:    w = 2 * 1024 + int'(dl) * 16 + int'(un) * 2 + int'(db);
      default: w = 3 * 1024;
    endcase
    return w[12:0];
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic drive_cycle(input logic v, input logic [1:0] op, input logic [3:0] valve,
                             input logic st, input logic [5:0] dl, input logic [2:0] un,
                             input logic db, input logic rw, input logic rs);
    logic          exp_ready;
    logic [W-1:0]  exp_w;
    logic [12:0]   word;
    logic [AW-1:0] a;
    cmd_valid = v;  cmd_op = op;   cmd_valve = valve; cmd_set = st;
    cmd_delay = dl; cmd_unit = un; cmd_debug = db;    rewind = rw; rst = rs;
    @(negedge clk);
    exp_ready = !m_done && !rw && !rs;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("prog_len", 32'(prog_len), 32'(m_len));
    chk("prog_done", 32'(prog_done), 32'(m_done));
    chk("dbg_state", 32'(dbg_state), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("err_illegal", 32'(err_illegal), 32'(e_err));
    if (err_illegal === 1'b1) err_count++;
    if (mem_we === 1'b1) begin
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL write: unexpected write addr %0d data 0x%0h", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        chk("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_w));
      end
    end
    e_we  = 1'b0;
    e_err = 1'b0;
    if (rs || rw) begin
      m_len  = 0;
      m_done = 1'b0;
      m_ovf  = 1'b0;
    end else if (v && exp_ready) begin
      if (op == 2'd3) begin
        e_err = 1'b1;
      end else begin
        word = ref_word(op, valve, st, dl, un, db);
        if (op == 2'd2 || m_len == DEPTH - 1) begin
          word   = 13'h0C00;
          m_done = 1'b1;
          if (op != 2'd2) m_ovf = 1'b1;
        end
        a = AW'(m_len);
        exp_q.push_back({a, word});
        e_we  = 1'b1;
        m_len = m_len + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 2'd0, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_rewind();
    drive_cycle(1'b0, 2'd0, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] valve, input logic st,
                      input logic [5:0] dl, input logic [2:0] un, input logic db);
    drive_cycle(1'b1, op, valve, st, dl, un, db, 1'b0, 1'b0);
  endtask

  task automatic check_reset();
    cmd_valid = 1'b0;
    rewind    = 1'b0;
    rst       = 1'b0;
    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_prog_len", 32'(prog_len), 32'd0);
    chk("rst_prog_done", 32'(prog_done), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_err_illegal", 32'(err_illegal), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wc0;
    int ec0;
    vecs[0] = '{2'd0, 4'd5,  1'b1, 6'd0,  3'd0, 1'b0, 13'h0542};
    vecs[1] = '{2'd1, 4'd0,  1'b0, 6'd10, 3'd3, 1'b0, 13'h08A6};
    vecs[2] = '{2'd2, 4'd15, 1'b1, 6'd63, 3'd7, 1'b1, 13'h0C00};
    vecs[3] = '{2'd0, 4'd15, 1'b0, 6'd63, 3'd7, 1'b1, 13'h07C0};
    vecs[4] = '{2'd1, 4'd12, 1'b1, 6'd63, 3'd7, 1'b1, 13'h0BFF};
    vecs[5] = '{2'd0, 4'd0,  1'b1, 6'd0,  3'd0, 1'b0, 13'h0402};
    vecs[6] = '{2'd1, 4'd9,  1'b1, 6'd0,  3'd0, 1'b1, 13'h0801};
    vecs[7] = '{2'd0, 4'd10, 1'b1, 6'd21, 3'd2, 1'b0, 13'h0682};

    // Clock/reset
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_valve = 4'd0; cmd_set = 1'b0;
    cmd_delay = 6'd0; cmd_unit = 3'd0; cmd_debug = 1'b0; rewind = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b0, 2'd0, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 2'd0, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check_reset();

    // Back-to-back set, delay, halt
    wc0 = wr_count;
    send(2'd0, 4'd5, 1'b1, 6'd0, 3'd0, 1'b0);
    send(2'd1, 4'd0, 1'b0, 6'd10, 3'd3, 1'b0);
    send(2'd2, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0);
    idle();
    chk("a_writes", 32'(wr_count - wc0), 32'd3);
    chk("a_halt_addr", 32'(last_wr_addr), 32'd2);
    chk("a_halt_word", 32'(last_wr_data), 32'h0C00);
    chk("a_prog_len", 32'(prog_len), 32'd3);
    chk("a_prog_done", 32'(prog_done), 32'd1);
    chk("a_cmd_ready", 32'(cmd_ready), 32'd0);

    // Encoding table
    for (int i = 0; i < 8; i++) begin
      pulse_rewind();
      send(vecs[i].op, vecs[i].valve, vecs[i].st, vecs[i].dl, vecs[i].un, vecs[i].db);
      idle();
      chk("tbl_word", 32'(last_wr_data), 32'(vecs[i].word));
      chk("tbl_addr", 32'(last_wr_addr), 32'd0);
    end

    // Fill to the last slot: forced halt, fifth command refused
    pulse_rewind();
    wc0 = wr_count;
    for (int i = 0; i < 5; i++) send(2'd0, 4'(i), 1'b1, 6'd0, 3'd0, 1'b0);
    idle();
    chk("ovf_writes", 32'(wr_count - wc0), 32'd4);
    chk("ovf_last_addr", 32'(last_wr_addr), 32'd3);
    chk("ovf_last_word", 32'(last_wr_data), 32'h0C00);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_prog_len", 32'(prog_len), 32'd4);
    chk("ovf_prog_done", 32'(prog_done), 32'd1);

    // Rewind together with cmd_valid while DONE
    wc0 = wr_count;
    drive_cycle(1'b1, 2'd0, 4'd7, 1'b1, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("rw_prog_len", 32'(prog_len), 32'd0);
    chk("rw_overflow", 32'(overflow), 32'd0);
    chk("rw_prog_done", 32'(prog_done), 32'd0);
    chk("rw_no_write", 32'(mem_we), 32'd0);
    send(2'd0, 4'd7, 1'b1, 6'd0, 3'd0, 1'b0);
    idle();
    chk("rw_writes", 32'(wr_count - wc0), 32'd1);
    chk("rw_addr", 32'(last_wr_addr), 32'd0);
    chk("rw_word", 32'(last_wr_data), 32'h05C2);

    // Illegal op between two sets
    pulse_rewind();
    ec0 = err_count;
    send(2'd0, 4'd1, 1'b1, 6'd0, 3'd0, 1'b0);
    send(2'd3, 4'd0, 1'b0, 6'd0, 3'd0, 1'b0);
    send(2'd0, 4'd2, 1'b0, 6'd0, 3'd0, 1'b0);
    idle();
    chk("ill_err_pulses", 32'(err_count - ec0), 32'd1);
    chk("ill_prog_len", 32'(prog_len), 32'd2);
    chk("ill_addr", 32'(last_wr_addr), 32'd1);
    chk("ill_word", 32'(last_wr_data), 32'h0480);

    // Valid toggled every other cycle
    pulse_rewind();
    wc0 = wr_count;
    for (int i = 0; i < 6; i++)
      drive_cycle((i % 2) == 0, 2'd0, 4'(i), 1'b1, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("stall_writes", 32'(wr_count - wc0), 32'd3);
    chk("stall_prog_len", 32'(prog_len), 32'd3);

    // rst in the cycle after an accept
    pulse_rewind();
    wc0 = wr_count;
    send(2'd0, 4'd3, 1'b1, 6'd0, 3'd0, 1'b0);
    drive_cycle(1'b1, 2'd0, 4'd4, 1'b1, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    check_reset();
    chk("rstmid_writes", 32'(wr_count - wc0), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
                  $urandom_range(0, 59) == 0);
    end
    idle();
    idle();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
